// File: rtl/washer_ctrl_prog.sv
// Programmable washing-machine controller: self-timed wash/spin phases,
// programmable rinse passes, pause in agitate/spin, and fill/drain
// watchdogs that latch a fault state until cleared.
module washer_ctrl_prog #(
  parameter int unsigned TW        = 16,
  parameter int unsigned RINSE_MAX = 3,
  parameter int unsigned RW        = 2,
  parameter int unsigned FILL_TO   = 1000,
  parameter int unsigned DRAIN_TO  = 1000
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic          doorclose,
  input  logic          filled,
  input  logic          drained,
  input  logic          detergent,
  input  logic          pause,
  input  logic          fault_clr,
  input  logic [TW-1:0] wash_time,
  input  logic [TW-1:0] spin_time,
  input  logic [RW-1:0] rinse_req,
  output logic          doorlock,
  output logic          fillvalve_on,
  output logic          drainvalve_on,
  output logic          motor_on,
  output logic          soap_wash,
  output logic          water_wash,
  output logic          done,
  output logic          fault,
  output logic [2:0]    state_out,
  output logic [RW-1:0] rinse_left
);

  localparam int unsigned WD_MAX = (FILL_TO > DRAIN_TO) ? FILL_TO : DRAIN_TO;
  localparam int unsigned WDW    = $clog2(WD_MAX + 1);
  localparam logic [WDW-1:0] FILL_LAST  = WDW'(FILL_TO - 1);
  localparam logic [WDW-1:0] DRAIN_LAST = WDW'(DRAIN_TO - 1);
  localparam logic [RW-1:0]  RMAX       = RW'(RINSE_MAX);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_FILL  = 3'd1,
    S_ADD   = 3'd2,
    S_WASH  = 3'd3,
    S_DRAIN = 3'd4,
    S_SPIN  = 3'd5,
    S_FAULT = 3'd6
  } state_e;

  state_e          state_q, state_d;
  logic [TW-1:0]   timer_q, timer_d;
  logic [TW-1:0]   wash_q, wash_d;
  logic [TW-1:0]   spin_q, spin_d;
  logic [WDW-1:0]  wd_q, wd_d;
  logic [RW-1:0]   rl_q, rl_d;
  logic            rp_q, rp_d;
  logic [RW-1:0]   rinse_clamp;

  logic doorlock_d, fill_d, drain_d, motor_d, soap_d, water_d, done_d, fault_d;

  assign rinse_clamp = (rinse_req > RMAX) ? RMAX : rinse_req;
  assign state_out   = state_q;
  assign rinse_left  = rl_q;

  // State and datapath registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      timer_q <= '0;
      wash_q  <= '0;
      spin_q  <= '0;
      wd_q    <= '0;
      rl_q    <= '0;
      rp_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      timer_q <= timer_d;
      wash_q  <= wash_d;
      spin_q  <= spin_d;
      wd_q    <= wd_d;
      rl_q    <= rl_d;
      rp_q    <= rp_d;
    end
  end

  // Next-state, phase timer, watchdog and rinse bookkeeping
  always_comb begin
    state_d = state_q;
    timer_d = timer_q;
    wash_d  = wash_q;
    spin_d  = spin_q;
    wd_d    = wd_q;
    rl_d    = rl_q;
    rp_d    = rp_q;

    case (state_q)
      S_IDLE: begin
        if (start && doorclose) begin
          state_d = S_FILL;
          wash_d  = wash_time;
          spin_d  = spin_time;
          rl_d    = rinse_clamp;
          rp_d    = 1'b0;
        end
      end
      S_FILL: begin
        if (filled)                state_d = rp_q ? S_WASH : S_ADD;
        else if (wd_q >= FILL_LAST) state_d = S_FAULT;
      end
      S_ADD: begin
        if (detergent) state_d = S_WASH;
      end
      S_WASH: begin
        if (!pause && (timer_q == '0)) state_d = S_DRAIN;
      end
      S_DRAIN: begin
        if (drained) begin
          if (rl_q == '0) begin
            state_d = S_SPIN;
          end else begin
            state_d = S_FILL;
            rl_d    = rl_q - RW'(1);
            rp_d    = 1'b1;
          end
        end else if (wd_q >= DRAIN_LAST) begin
          state_d = S_FAULT;
        end
      end
      S_SPIN: begin
        if (!pause && (timer_q == '0)) state_d = S_IDLE;
      end
      S_FAULT: begin
        if (fault_clr) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    // Phase timer loads on entry and counts down only while running unpaused
    if ((state_d != state_q) && (state_d == S_WASH)) begin
      timer_d = wash_q;
    end else if ((state_d != state_q) && (state_d == S_SPIN)) begin
      timer_d = spin_q;
    end else if (((state_q == S_WASH) || (state_q == S_SPIN)) && !pause && (timer_q != '0)) begin
      timer_d = timer_q - TW'(1);
    end

    // Watchdog clears on entry to FILL/DRAIN and saturates rather than wrapping
    if ((state_d != state_q) && ((state_d == S_FILL) || (state_d == S_DRAIN))) begin
      wd_d = '0;
    end else if (((state_q == S_FILL) || (state_q == S_DRAIN)) && (wd_q != '1)) begin
      wd_d = wd_q + WDW'(1);
    end
  end

  // Output decode from the next state so outputs move with state_out
  always_comb begin
    doorlock_d = 1'b0;
    fill_d     = 1'b0;
    drain_d    = 1'b0;
    motor_d    = 1'b0;
    soap_d     = 1'b0;
    water_d    = 1'b0;
    fault_d    = 1'b0;
    done_d     = (state_q == S_SPIN) && (state_d == S_IDLE);
    case (state_d)
      S_FILL:  begin doorlock_d = 1'b1; fill_d = 1'b1; end
      S_ADD:   begin doorlock_d = 1'b1; soap_d = 1'b1; end
      S_WASH:  begin
        doorlock_d = 1'b1;
        soap_d     = ~rp_d;
        water_d    = rp_d;
        motor_d    = ~pause;
      end
      S_DRAIN: begin doorlock_d = 1'b1; drain_d = 1'b1; end
      S_SPIN:  begin
        doorlock_d = 1'b1;
        drain_d    = 1'b1;
        water_d    = 1'b1;
        motor_d    = ~pause;
      end
      S_FAULT: begin doorlock_d = 1'b1; drain_d = 1'b1; fault_d = 1'b1; end
      default: ;
    endcase
  end

  // Registered actuator and status outputs
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      doorlock      <= 1'b0;
      fillvalve_on  <= 1'b0;
      drainvalve_on <= 1'b0;
      motor_on      <= 1'b0;
      soap_wash     <= 1'b0;
      water_wash    <= 1'b0;
      done          <= 1'b0;
      fault         <= 1'b0;
    end else begin
      doorlock      <= doorlock_d;
      fillvalve_on  <= fill_d;
      drainvalve_on <= drain_d;
      motor_on      <= motor_d;
      soap_wash     <= soap_d;
      water_wash    <= water_d;
      done          <= done_d;
      fault         <= fault_d;
    end
  end

endmodule

// File: doc/washer_ctrl_prog.md
Name: washer_ctrl_prog

Overview:
- Parametrised, self-timed successor to the fixed-sequence washing-machine controller.
- Adds internal wash and spin timers loaded from per-cycle programmable durations, a programmable number of rinse passes, and pause on agitate/spin.
- Adds fill/drain watchdog timeouts with a latched fault state.
- Sits between the front-panel/sensor interface and the valve/motor drivers.

Parameters:
- TW, 16: width of the wash/spin duration inputs and the internal phase timer.
- RINSE_MAX, 3: maximum rinse passes; rinse_req is clamped to this value.
- RW, 2: width of rinse_req and rinse_left; must hold RINSE_MAX.
- FILL_TO, 1000: cycles allowed in FILL before fault.
- DRAIN_TO, 1000: cycles allowed in DRAIN before fault.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- start  in  1  begin a program; honoured only in IDLE with doorclose=1.
- doorclose  in  1  door-closed sensor.
- filled  in  1  drum-full sensor.
- drained  in  1  drum-empty sensor.
- detergent  in  1  detergent-dispensed acknowledge.
- pause  in  1  hold the timer and stop the motor in WASH/SPIN.
- fault_clr  in  1  leave FAULT.
- wash_time  in  TW  agitate duration in cycles, sampled at start.
- spin_time  in  TW  spin duration in cycles, sampled at start.
- rinse_req  in  RW  number of rinse passes, sampled at start.
- doorlock, fillvalve_on, drainvalve_on, motor_on, soap_wash, water_wash  out  1 each  actuator controls.
- done  out  1  one-cycle completion pulse.
- fault  out  1  high while in FAULT.
- state_out  out  3  current state encoding.
- rinse_left  out  RW  rinse passes remaining.

Behaviour:
- States: IDLE=0, FILL=1, ADD_DET=2, WASH=3, DRAIN=4, SPIN=5, FAULT=6. Encoding 7 is illegal and goes to IDLE on the next edge.
- Internal registers: state, timer[TW], wd (watchdog counter), rinse_left, rinse_pass flag, latched wash/spin durations, done.
- All outputs are registered and decoded from the next state, so each output changes on the same edge as state_out.
- Reset (rst=0, asynchronous): state=IDLE, all outputs 0, timer=0, wd=0, rinse_left=0, rinse_pass=0.
- IDLE:
  - All actuators off; doorlock=0.
  - start&&doorclose -> FILL; latch wash_time and spin_time; rinse_left=min(rinse_req,RINSE_MAX); rinse_pass=0.
  - start while not in IDLE is ignored.
- FILL:
  - doorlock=1, fillvalve_on=1, wd increments each cycle.
  - filled -> ADD_DET if rinse_pass=0, else WASH with timer=wash_time.
  - If wd reaches FILL_TO-1 with filled=0 -> FAULT. filled wins on the same cycle.
- ADD_DET:
  - doorlock=1, soap_wash=1.
  - detergent -> WASH with timer=wash_time.
  - Waits indefinitely; no timeout.
- WASH:
  - doorlock=1; soap_wash=~rinse_pass; water_wash=rinse_pass; motor_on=~pause.
  - When pause=0: if timer==0 -> DRAIN, else timer decrements.
  - When pause=1: timer holds and no exit.
  - Unpaused duration is wash_time+1 cycles; wash_time=0 gives 1 cycle.
- DRAIN:
  - doorlock=1, drainvalve_on=1, wd increments.
  - On drained with rinse_left==0 -> SPIN with timer=spin_time.
  - On drained with rinse_left>0 -> FILL; rinse_left decrements; rinse_pass=1.
  - If wd reaches DRAIN_TO-1 with drained=0 -> FAULT. drained wins on the same cycle.
- SPIN:
  - doorlock=1, drainvalve_on=1, water_wash=1, motor_on=~pause.
  - Timer rule is the same as WASH.
  - On exit -> IDLE; done=1 for exactly the first IDLE cycle; doorlock drops on the same edge.
- FAULT:
  - fault=1, doorlock=1, drainvalve_on=1, all else 0.
  - fault_clr -> IDLE. start is ignored.
- wd clears on every entry to FILL or DRAIN and saturates; it never wraps.
- Simultaneous pause and timer==0: pause wins, so the machine stays in WASH/SPIN.
- doorclose is ignored once the machine leaves IDLE; the door is locked.
- Input changes after start do not affect the running program.

Test Plan:
- Basic run: wash_time=3, spin_time=2, rinse_req=0, sensors acknowledge after 1 cycle -> sequence IDLE,FILL,ADD_DET,WASH(4 cycles, motor_on=1, soap_wash=1),DRAIN,SPIN(3 cycles),IDLE; done high for exactly 1 cycle; doorlock=0 afterwards.
- Rinses: rinse_req=2 -> after the soap wash: DRAIN,FILL,WASH(water_wash=1, soap_wash=0) twice; rinse_left shows 1 then 0; ADD_DET is visited only once.
- Pause: pause=1 for 5 cycles mid-WASH with wash_time=3 -> motor_on=0 and timer frozen; WASH totals 4+5=9 cycles; same check in SPIN.
- Fill timeout: FILL_TO=8, filled held 0 -> FAULT entered 8 cycles after FILL entry; fault=1, drainvalve_on=1, doorlock=1; start ignored; fault_clr -> IDLE with all outputs 0.
- Boundaries: wash_time=0 gives a 1-cycle WASH; rinse_req=3 with RINSE_MAX=2 yields 2 rinses; filled asserted on the timeout cycle -> no fault.
- Reset mid-operation: rst=0 during SPIN -> outputs clear immediately, without a clock edge; after release, start with doorclose=0 stays in IDLE.
